arbitro_rr_mux4: RTL and testbench

- Round-robin arbiter/sequencer that shares one 4-bit result bus among four requesters (ALU sub-units, operand sources).
- Owns the 2-bit select of a mux_4_para_1_4bits instance and drives it from a registered grant.
- Presents a valid/ready output stream with a same-cycle per-requester acknowledge.
- Sits between the ALU functional units and the result register/bus consumer.

---
 rtl/arbitro_rr_mux4_pkg.sv | 13 +
 rtl/mux_4_para_1_4bits.sv | 22 ++
 rtl/seletor_rr_4.sv | 22 ++
 rtl/arbitro_rr_mux4.sv | 128 ++++++++++++
 tb/tb_arbitro_rr_mux4.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_rr_mux4_pkg.sv
// Shared definitions for the round-robin result-bus arbiter: state encoding,
// requester count and data width.
package arbitro_rr_mux4_pkg;

    typedef enum logic {
        ARB_OCIOSO    = 1'b0,
        ARB_CONCEDIDO = 1'b1
    } estado_t;

    localparam int NUM_REQ   = 4;
    localparam int LARG_DADO = 4;

endpackage

// File: rtl/mux_4_para_1_4bits.sv
// Four-input, 4-bit wide data multiplexer selected by S.
module mux_4_para_1_4bits
    import arbitro_rr_mux4_pkg::*;
(
    input  logic [LARG_DADO-1:0] D0,
    input  logic [LARG_DADO-1:0] D1,
    input  logic [LARG_DADO-1:0] D2,
    input  logic [LARG_DADO-1:0] D3,
    input  logic [1:0]           S,
    output logic [LARG_DADO-1:0] Y
);

    always_comb begin
        case (S)
            2'd0:    Y = D0;
            2'd1:    Y = D1;
            2'd2:    Y = D2;
            default: Y = D3;
        endcase
    end

endmodule

// File: rtl/seletor_rr_4.sv
// Combinational round-robin pick: first requester found scanning from ponteiro
// upward, wrapping 3 -> 0.
module seletor_rr_4
    import arbitro_rr_mux4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ponteiro,
    output logic [1:0]         idx,
    output logic               algum
);

    // Scan from the far end so the closest requester to ponteiro wins.
    always_comb begin
        idx = ponteiro;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[ponteiro + 2'(k)]) idx = ponteiro + 2'(k);
        end
    end

    assign algum = |req;

endmodule

// File: rtl/arbitro_rr_mux4.sv
// Round-robin arbiter sharing one 4-bit result bus among four requesters.
// Optional burst mode (several transfers per grant) enabled by ARB_RAJADA_EN.
//
//   state         | meaning
//   ARB_OCIOSO    | no grant held, y_valido = 0, waiting for any req
//   ARB_CONCEDIDO | sel owns the bus, word offered while req[sel] = 1
module arbitro_rr_mux4
    import arbitro_rr_mux4_pkg::*;
#(
    parameter int PRIO_INICIAL = 0,
    parameter int RAJADA_MAX   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [LARG_DADO-1:0] D0,
    input  logic [LARG_DADO-1:0] D1,
    input  logic [LARG_DADO-1:0] D2,
    input  logic [LARG_DADO-1:0] D3,
    output logic [NUM_REQ-1:0]   ack,
    output logic [LARG_DADO-1:0] Y,
    output logic                 y_valido,
    input  logic                 y_pronto,
    output logic [1:0]           y_origem
);

    localparam logic [1:0] PRIO = 2'(PRIO_INICIAL);

    if (RAJADA_MAX < 1 || RAJADA_MAX > 15) begin : g_rajada_invalida
        $error("RAJADA_MAX must be in 1..15");
    end

    estado_t    estado;
    logic [1:0] sel;
    logic [1:0] ponteiro;
    logic [1:0] prox_ponteiro;
    logic [1:0] idx_atual;
    logic [1:0] idx_prox;
    logic       algum_atual;
    logic       algum_prox;
    logic       transfer;
    logic       manter;

    assign prox_ponteiro = sel + 2'd1;

    // Second picker looks ahead with the rotated pointer so a new grant is
    // ready on the same edge as a transfer, giving back-to-back throughput.
    seletor_rr_4 u_sel_atual (
        .req      (req),
        .ponteiro (ponteiro),
        .idx      (idx_atual),
        .algum    (algum_atual)
    );

    seletor_rr_4 u_sel_prox (
        .req      (req),
        .ponteiro (prox_ponteiro),
        .idx      (idx_prox),
        .algum    (algum_prox)
    );

    mux_4_para_1_4bits u_mux (
        .D0 (D0),
        .D1 (D1),
        .D2 (D2),
        .D3 (D3),
        .S  (sel),
        .Y  (Y)
    );

    // Gated by rst so a grant abandoned by reset never acknowledges a word.
    assign y_valido = (estado == ARB_CONCEDIDO) && req[sel] && !rst;
    assign transfer = y_valido && y_pronto;
    assign ack      = transfer ? (4'b0001 << sel) : 4'b0000;
    assign y_origem = sel;

`ifdef ARB_RAJADA_EN
    logic [3:0] contador;
    assign manter = ({1'b0, contador} + 5'd1) < 5'(RAJADA_MAX);
`else
    assign manter = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= ARB_OCIOSO;
            sel      <= PRIO;
            ponteiro <= PRIO;
`ifdef ARB_RAJADA_EN
            contador <= 4'd0;
`endif
        end else begin
            case (estado)
                ARB_OCIOSO: begin
`ifdef ARB_RAJADA_EN
                    contador <= 4'd0;
`endif
                    if (algum_atual) begin
                        sel    <= idx_atual;
                        estado <= ARB_CONCEDIDO;
                    end
                end
                ARB_CONCEDIDO: begin
                    if (transfer && !manter) begin
                        ponteiro <= prox_ponteiro;
`ifdef ARB_RAJADA_EN
                        contador <= 4'd0;
`endif
                        if (algum_prox) sel    <= idx_prox;
                        else            estado <= ARB_OCIOSO;
`ifdef ARB_RAJADA_EN
                    end else if (transfer) begin
                        contador <= contador + 4'd1;
`endif
                    end else if (!req[sel]) begin
                        // Requester withdrew without ack: re-pick, pointer kept.
`ifdef ARB_RAJADA_EN
                        contador <= 4'd0;
`endif
                        if (algum_atual) sel    <= idx_atual;
                        else             estado <= ARB_OCIOSO;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_rr_mux4.sv
// Self-checking bench for arbitro_rr_mux4: reset, fairness, back-pressure,
// wrap, protocol violation, mid-grant reset and burst ordering.
module tb_arbitro_rr_mux4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] D0, D1, D2, D3;
    logic [3:0] ack;
    logic [3:0] Y;
    logic       y_valido;
    logic       y_pronto;
    logic [1:0] y_origem;

    typedef struct {
        logic [1:0] origem;
        logic [3:0] dado;
    } esp_t;

    esp_t fila[$];
    int   n_comp  = 0;
    int   n_falha = 0;

    always #5 clk = ~clk;

    arbitro_rr_mux4 #(
        .PRIO_INICIAL (0),
        .RAJADA_MAX   (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .D0       (D0),
        .D1       (D1),
        .D2       (D2),
        .D3       (D3),
        .ack      (ack),
        .Y        (Y),
        .y_valido (y_valido),
        .y_pronto (y_pronto),
        .y_origem (y_origem)
    );

    task automatic ciclo(input logic [3:0] r, input logic p);
        @(negedge clk);
        req      = r;
        y_pronto = p;
        #1;
    endtask

    task automatic reinicia();
        @(negedge clk);
        rst = 1'b1; req = 4'b0; y_pronto = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic dados_padrao();
        D0 = 4'd5; D1 = 4'd6; D2 = 4'd7; D3 = 4'd8;
    endtask

    task automatic test_reset();
        D0 = 4'h1; D1 = 4'h2; D2 = 4'hA; D3 = 4'h3;
        rst = 1'b1; req = 4'b0; y_pronto = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_comp++;
            if ({y_valido, ack, y_origem, Y} !== {1'b0, 4'b0, 2'd0, 4'h1}) begin
                n_falha++;
                $display("FAIL reset_hold cyc %0d: got %h need %h", c, {y_valido, ack, y_origem, Y}, {1'b0, 4'b0, 2'd0, 4'h1});
            end
        end
        @(negedge clk); rst = 1'b0; #1;
        n_comp++;
        if ({y_valido, ack, y_origem, Y} !== {1'b0, 4'b0, 2'd0, 4'h1}) begin
            n_falha++;
            $display("FAIL reset_after: got %h need %h", {y_valido, ack, y_origem, Y}, {1'b0, 4'b0, 2'd0, 4'h1});
        end
        ciclo(4'b0100, 1'b1);
        fila.push_back('{2'd2, 4'hA});
        n_comp++;
        if (y_valido !== 1'b0) begin
            n_falha++;
            $display("FAIL reset_idle_valid: got %b need 0", y_valido);
        end
        ciclo(4'b0100, 1'b1);
        n_comp++;
        if (fila.size() == 0) begin
            n_falha++;
            $display("FAIL reset_first_grant: scoreboard empty");
        end else begin
            esp_t e = fila.pop_front();
            if ({y_valido, ack, y_origem, Y} !== {1'b1, 4'b0001 << e.origem, e.origem, e.dado}) begin
                n_falha++;
                $display("FAIL reset_first_grant: got %h need %h", {y_valido, ack, y_origem, Y}, {1'b1, 4'b0001 << e.origem, e.origem, e.dado});
            end
        end
    endtask

    task automatic test_equidade();
        dados_padrao();
        reinicia();
        ciclo(4'b1111, 1'b1);
        n_comp++;
        if (y_valido !== 1'b0) begin
            n_falha++;
            $display("FAIL fair_idle_valid: got %b need 0", y_valido);
        end
        for (int i = 0; i < 5; i++) fila.push_back('{2'(i), 4'(5 + (i % 4))});
        for (int i = 0; i < 5; i++) begin
            ciclo(4'b1111, 1'b1);
            n_comp++;
            if (fila.size() == 0) begin
                n_falha++;
                $display("FAIL fair_grant %0d: scoreboard empty", i);
            end else begin
                esp_t e = fila.pop_front();
                if ({y_valido, ack, y_origem, Y} !== {1'b1, 4'b0001 << e.origem, e.origem, e.dado}) begin
                    n_falha++;
                    $display("FAIL fair_grant %0d: got %h need %h", i, {y_valido, ack, y_origem, Y}, {1'b1, 4'b0001 << e.origem, e.origem, e.dado});
                end
            end
        end
    endtask

    task automatic test_contrapressao();
        for (int i = 0; i < 5; i++) begin
            ciclo(4'b1111, 1'b0);
            n_comp++;
            if ({y_valido, ack, y_origem, Y} !== {1'b1, 4'b0, 2'd1, 4'd6}) begin
                n_falha++;
                $display("FAIL stall %0d: got %h need %h", i, {y_valido, ack, y_origem, Y}, {1'b1, 4'b0, 2'd1, 4'd6});
            end
        end
        for (int i = 1; i < 4; i++) fila.push_back('{2'(i), 4'(5 + i)});
        for (int i = 0; i < 3; i++) begin
            ciclo(4'b1111, 1'b1);
            n_comp++;
            if (fila.size() == 0) begin
                n_falha++;
                $display("FAIL stall_release %0d: scoreboard empty", i);
            end else begin
                esp_t e = fila.pop_front();
                if ({y_valido, ack, y_origem, Y} !== {1'b1, 4'b0001 << e.origem, e.origem, e.dado}) begin
                    n_falha++;
                    $display("FAIL stall_release %0d: got %h need %h", i, {y_valido, ack, y_origem, Y}, {1'b1, 4'b0001 << e.origem, e.origem, e.dado});
                end
            end
        end
    endtask

    task automatic test_volta_unico();
        logic [3:0] reqs [6];
        logic [1:0] ords [6];
        reqs = '{4'b0001, 4'b0001, 4'b0001, 4'b1001, 4'b1001, 4'b1001};
        ords = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
        dados_padrao();
        reinicia();
        ciclo(4'b0100, 1'b1);
        ciclo(4'b0100, 1'b1);
        n_comp++;
        if ({y_valido, ack, y_origem, Y} !== {1'b1, 4'b0100, 2'd2, 4'd7}) begin
            n_falha++;
            $display("FAIL wrap_setup: got %h need %h", {y_valido, ack, y_origem, Y}, {1'b1, 4'b0100, 2'd2, 4'd7});
        end
        // requester 2 leaves after its ack; the re-granted slot is now empty
        ciclo(4'b0001, 1'b1);
        n_comp++;
        if ({y_valido, ack, y_origem} !== {1'b0, 4'b0, 2'd2}) begin
            n_falha++;
            $display("FAIL wrap_dropped: got %h need %h", {y_valido, ack, y_origem}, {1'b0, 4'b0, 2'd2});
        end
        for (int i = 0; i < 6; i++) fila.push_back('{ords[i], 4'(5 + ords[i])});
        for (int i = 0; i < 6; i++) begin
            ciclo(reqs[i], 1'b1);
            n_comp++;
            if (fila.size() == 0) begin
                n_falha++;
                $display("FAIL wrap_grant %0d: scoreboard empty", i);
            end else begin
                esp_t e = fila.pop_front();
                if ({y_valido, ack, y_origem, Y} !== {1'b1, 4'b0001 << e.origem, e.origem, e.dado}) begin
                    n_falha++;
                    $display("FAIL wrap_grant %0d: got %h need %h", i, {y_valido, ack, y_origem, Y}, {1'b1, 4'b0001 << e.origem, e.origem, e.dado});
                end
            end
        end
    endtask

    task automatic test_violacao_reset();
        dados_padrao();
        reinicia();
        ciclo(4'b0011, 1'b0);
        ciclo(4'b0011, 1'b0);
        n_comp++;
        if ({y_valido, ack, y_origem, Y} !== {1'b1, 4'b0, 2'd0, 4'd5}) begin
            n_falha++;
            $display("FAIL viol_stall: got %h need %h", {y_valido, ack, y_origem, Y}, {1'b1, 4'b0, 2'd0, 4'd5});
        end
        ciclo(4'b0010, 1'b0);
        n_comp++;
        if ({y_valido, ack, y_origem} !== {1'b0, 4'b0, 2'd0}) begin
            n_falha++;
            $display("FAIL viol_drop: got %h need %h", {y_valido, ack, y_origem}, {1'b0, 4'b0, 2'd0});
        end
        ciclo(4'b0010, 1'b0);
        n_comp++;
        if ({y_valido, ack, y_origem, Y} !== {1'b1, 4'b0, 2'd1, 4'd6}) begin
            n_falha++;
            $display("FAIL viol_repick: got %h need %h", {y_valido, ack, y_origem, Y}, {1'b1, 4'b0, 2'd1, 4'd6});
        end
        ciclo(4'b0110, 1'b1);
        n_comp++;
        if (ack !== 4'b0010) begin
            n_falha++;
            $display("FAIL viol_ack: got %b need 0010", ack);
        end
        // pointer now 2 and grant on 2; reset must abandon it
        @(negedge clk);
        rst = 1'b1; req = 4'b0101; y_pronto = 1'b1; #1;
        n_comp++;
        if ({y_valido, ack} !== {1'b0, 4'b0}) begin
            n_falha++;
            $display("FAIL midrst_noack: got %h need %h", {y_valido, ack}, {1'b0, 4'b0});
        end
        @(negedge clk); rst = 1'b0; #1;
        n_comp++;
        if ({y_valido, ack, y_origem, Y} !== {1'b0, 4'b0, 2'd0, 4'd5}) begin
            n_falha++;
            $display("FAIL midrst_after: got %h need %h", {y_valido, ack, y_origem, Y}, {1'b0, 4'b0, 2'd0, 4'd5});
        end
        ciclo(4'b0101, 1'b1);
        n_comp++;
        if ({y_valido, ack, y_origem, Y} !== {1'b1, 4'b0001, 2'd0, 4'd5}) begin
            n_falha++;
            $display("FAIL midrst_first: got %h need %h", {y_valido, ack, y_origem, Y}, {1'b1, 4'b0001, 2'd0, 4'd5});
        end
    endtask

    task automatic test_rajada();
`ifdef ARB_RAJADA_EN
        logic [1:0] ords [7];
        ords = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
`else
        logic [1:0] ords [4];
        ords = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
        dados_padrao();
        reinicia();
        ciclo(4'b0011, 1'b1);
        foreach (ords[i]) fila.push_back('{ords[i], 4'(5 + ords[i])});
        foreach (ords[i]) begin
            ciclo(4'b0011, 1'b1);
            n_comp++;
            if (fila.size() == 0) begin
                n_falha++;
                $display("FAIL burst_grant %0d: scoreboard empty", i);
            end else begin
                esp_t e = fila.pop_front();
                if ({y_valido, ack, y_origem, Y} !== {1'b1, 4'b0001 << e.origem, e.origem, e.dado}) begin
                    n_falha++;
                    $display("FAIL burst_grant %0d: got %h need %h", i, {y_valido, ack, y_origem, Y}, {1'b1, 4'b0001 << e.origem, e.origem, e.dado});
                end
            end
        end
        n_comp++;
        if (fila.size() != 0) begin
            n_falha++;
            $display("FAIL scoreboard_drain: got %0d left need 0", fila.size());
        end
    endtask

    initial begin
        test_reset();
        test_equidade();
        test_contrapressao();
        test_volta_unico();
        test_violacao_reset();
        test_rajada();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_falha);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
